// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - opcode, state and output encodings for the multi-cycle controller
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
  } ctrlState;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_IMM    = 2'b01;
  localparam logic [1:0] PC_RS1IMM = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;
  localparam logic [1:0] M2R_IMM = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_FETCH_TO = 2'b10;
  localparam logic [1:0] CAUSE_DATA_TO  = 2'b11;

  function automatic logic isKnownOp(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: isKnownOp = 1'b1;
      default:                           isKnownOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - decoder/datapath/memory-port signals of the controller
interface multicycle_controller_if;
  logic       go_contr;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       comparator;
  logic       mem_ready;
  logic       irEn;
  logic       pcEn;
  logic [1:0] pc_select;
  logic       aluSrc;
  logic       regWrite;
  logic [1:0] memToReg;
  logic       isByte;
  logic       isHalf;
  logic       isWord;
  logic       isUnsigned;
  logic       memRead;
  logic       memWrite;
  logic       done;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  go_contr, opcode, func3, func7, comparator, mem_ready,
    output irEn, pcEn, pc_select, aluSrc, regWrite, memToReg,
           isByte, isHalf, isWord, isUnsigned, memRead, memWrite,
           done, trap, trap_cause
  );

  modport slave (
    output go_contr, opcode, func3, func7, comparator, mem_ready,
    input  irEn, pcEn, pc_select, aluSrc, regWrite, memToReg,
           isByte, isHalf, isWord, isUnsigned, memRead, memWrite,
           done, trap, trap_cause
  );
endinterface

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - memory wait-state counter; expired marks the last allowed cycle
module ctrl_wait_timer #(
  parameter int LIMIT = 15,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with memory handshake and traps
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1)
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);

  ctrlState   state, nextState;
  logic [6:0] opReg;
  logic [2:0] f3Reg;
  logic [6:0] unusedFunc7;
  logic [1:0] causeReg, nextCause;
  logic       waitState, timerExpired;

  assign waitState = (state == FETCH) || (state == MEM);

  ctrl_wait_timer #(.LIMIT(MEM_WAIT_MAX), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!waitState),
    .en      (waitState && !bus.mem_ready),
    .expired (timerExpired)
  );

  logic isR, isLoad, isStore, isBranch, isJal, isJalr, isLui;
  assign isR      = (opReg == OP_R);
  assign isLoad   = (opReg == OP_LOAD);
  assign isStore  = (opReg == OP_STORE);
  assign isBranch = (opReg == OP_BRANCH);
  assign isJal    = (opReg == OP_JAL);
  assign isJalr   = (opReg == OP_JALR);
  assign isLui    = (opReg == OP_LUI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      opReg       <= '0;
      f3Reg       <= '0;
      unusedFunc7 <= '0;
      causeReg    <= CAUSE_NONE;
    end else begin
      state    <= nextState;
      causeReg <= nextCause;
      if (state == DECODE) begin
        opReg       <= bus.opcode;
        f3Reg       <= bus.func3;
        unusedFunc7 <= bus.func7;
      end
    end
  end

  always_comb begin
    nextState      = state;
    nextCause      = causeReg;
    bus.irEn       = 1'b0;
    bus.pcEn       = 1'b0;
    bus.pc_select  = PC_PLUS4;
    bus.aluSrc     = 1'b0;
    bus.regWrite   = 1'b0;
    bus.memToReg   = M2R_ALU;
    bus.isByte     = 1'b0;
    bus.isHalf     = 1'b0;
    bus.isWord     = 1'b0;
    bus.isUnsigned = 1'b0;
    bus.memRead    = 1'b0;
    bus.memWrite   = 1'b0;
    bus.done       = 1'b0;
    bus.trap       = 1'b0;
    bus.trap_cause = CAUSE_NONE;

    case (state)
      IDLE: if (bus.go_contr) nextState = FETCH;
      FETCH: begin
        bus.memRead = 1'b1;
        bus.isWord  = 1'b1;
        if (bus.mem_ready) begin
          bus.irEn  = 1'b1;
          nextState = DECODE;
        end else if (timerExpired) begin
          nextState = TRAP;
          nextCause = CAUSE_FETCH_TO;
        end
      end
      DECODE: begin
        // Classify on the live opcode; it is latched on this same edge.
        if (isKnownOp(bus.opcode)) begin
          nextState = EXEC;
        end else begin
          nextState = TRAP;
          nextCause = CAUSE_ILLEGAL;
        end
      end
      EXEC: begin
        bus.aluSrc = !isR;
        if (isBranch) begin
          bus.pcEn      = 1'b1;
          bus.pc_select = bus.comparator ? PC_IMM : PC_PLUS4;
          bus.done      = 1'b1;
          nextState     = IDLE;
        end else if (isLoad || isStore) begin
          nextState = MEM;
        end else begin
          nextState = WB;
        end
      end
      MEM: begin
        bus.memRead    = isLoad;
        bus.memWrite   = isStore;
        bus.isByte     = (f3Reg[1:0] == 2'b00);
        bus.isHalf     = (f3Reg[1:0] == 2'b01);
        bus.isWord     = f3Reg[1];
        bus.isUnsigned = isLoad && f3Reg[2];
        if (bus.mem_ready) begin
          if (isLoad) begin
            nextState = WB;
          end else begin
            bus.pcEn  = 1'b1;
            bus.done  = 1'b1;
            nextState = IDLE;
          end
        end else if (timerExpired) begin
          nextState = TRAP;
          nextCause = CAUSE_DATA_TO;
        end
      end
      WB: begin
        bus.regWrite = 1'b1;
        bus.pcEn     = 1'b1;
        bus.done     = 1'b1;
        nextState    = IDLE;
        if (isLoad)              bus.memToReg = M2R_MEM;
        else if (isJal || isJalr) bus.memToReg = M2R_PC4;
        else if (isLui)          bus.memToReg = M2R_IMM;
        if (isJal)       bus.pc_select = PC_IMM;
        else if (isJalr) bus.pc_select = PC_RS1IMM;
      end
      TRAP: begin
        bus.trap       = 1'b1;
        bus.trap_cause = causeReg;
        if (!bus.go_contr) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  typedef struct packed {
    logic       irEn;
    logic       pcEn;
    logic [1:0] pcSel;
    logic       aluSrc;
    logic       regWrite;
    logic [1:0] m2r;
    logic       isByte;
    logic       isHalf;
    logic       isWord;
    logic       isUns;
    logic       memRead;
    logic       memWrite;
    logic       done;
    logic       trap;
    logic [1:0] cause;
  } outs_t;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  multicycle_controller_if bus();

  multicycle_controller #(.MEM_WAIT_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t sample();
    return {bus.irEn, bus.pcEn, bus.pc_select, bus.aluSrc, bus.regWrite, bus.memToReg,
            bus.isByte, bus.isHalf, bus.isWord, bus.isUnsigned, bus.memRead, bus.memWrite,
            bus.done, bus.trap, bus.trap_cause};
  endfunction

  task automatic chk(input string tag, input outs_t e);
    outs_t o;
    o = sample();
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue go with mem_ready high, check IDLE/FETCH/DECODE, leave the bench in EXEC.
  task automatic startInstr(input string tag, input logic [6:0] op, input logic [2:0] f3);
    outs_t e;
    bus.opcode    = op;
    bus.func3     = f3;
    bus.func7     = 7'h00;
    bus.mem_ready = 1'b1;
    bus.go_contr  = 1'b1;
    e = '0;
    chk({tag, "_idle"}, e);
    step();
    e = '0; e.irEn = 1'b1; e.memRead = 1'b1; e.isWord = 1'b1;
    chk({tag, "_fetch"}, e);
    bus.go_contr = 1'b0;
    step();
    e = '0;
    chk({tag, "_decode"}, e);
    step();
  endtask

  initial begin
    outs_t e;
    reset          = 1'b1;
    bus.go_contr   = 1'b0;
    bus.opcode     = 7'h00;
    bus.func3      = 3'h0;
    bus.func7      = 7'h00;
    bus.comparator = 1'b0;
    bus.mem_ready  = 1'b0;
    #1;
    e = '0;
    chk("reset_outputs", e);
    step();
    step();
    reset = 1'b0;
    step();

    // R-type: done at cycle 4 through WB
    startInstr("r", 7'b0110011, 3'b000);
    e = '0;
    chk("r_exec", e);
    step();
    e = '0; e.regWrite = 1'b1; e.pcEn = 1'b1; e.done = 1'b1;
    chk("r_wb", e);
    step();
    e = '0;
    chk("r_back_idle", e);

    // LBU with three wait cycles in MEM
    startInstr("lbu", 7'b0000011, 3'b100);
    bus.mem_ready = 1'b0;
    e = '0; e.aluSrc = 1'b1;
    chk("lbu_exec", e);
    step();
    e = '0; e.memRead = 1'b1; e.isByte = 1'b1; e.isUns = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lbu_mem_wait%0d", i), e);
      step();
    end
    bus.mem_ready = 1'b1;
    chk("lbu_mem_ready", e);
    step();
    e = '0; e.regWrite = 1'b1; e.pcEn = 1'b1; e.done = 1'b1; e.m2r = 2'b01;
    chk("lbu_wb", e);
    step();

    // BEQ not taken, then taken: done at cycle 3
    bus.comparator = 1'b0;
    startInstr("beq0", 7'b1100011, 3'b000);
    e = '0; e.aluSrc = 1'b1; e.pcEn = 1'b1; e.done = 1'b1; e.pcSel = 2'b00;
    chk("beq0_exec", e);
    step();
    e = '0;
    chk("beq0_idle", e);
    bus.comparator = 1'b1;
    startInstr("beq1", 7'b1100011, 3'b000);
    e = '0; e.aluSrc = 1'b1; e.pcEn = 1'b1; e.done = 1'b1; e.pcSel = 2'b01;
    chk("beq1_exec", e);
    step();
    bus.comparator = 1'b0;

    // JALR
    startInstr("jalr", 7'b1100111, 3'b000);
    e = '0; e.aluSrc = 1'b1;
    chk("jalr_exec", e);
    step();
    e = '0; e.regWrite = 1'b1; e.pcEn = 1'b1; e.done = 1'b1; e.pcSel = 2'b10; e.m2r = 2'b10;
    chk("jalr_wb", e);
    step();

    // LUI; opcode changed after DECODE must be ignored
    startInstr("lui", 7'b0110111, 3'b000);
    bus.opcode = 7'b1100011;
    e = '0; e.aluSrc = 1'b1;
    chk("lui_exec_latched", e);
    step();
    e = '0; e.regWrite = 1'b1; e.pcEn = 1'b1; e.done = 1'b1; e.m2r = 2'b11;
    chk("lui_wb", e);
    step();

    // SW with mem_ready high: done in MEM at cycle 4
    startInstr("sw", 7'b0100011, 3'b010);
    step();
    e = '0; e.memWrite = 1'b1; e.isWord = 1'b1; e.pcEn = 1'b1; e.done = 1'b1;
    chk("sw_mem_done", e);
    step();
    e = '0;
    chk("sw_idle", e);

    // Fetch timeout: 15 FETCH cycles then TRAP cause 10, held while go stays high
    bus.mem_ready = 1'b0;
    bus.go_contr  = 1'b1;
    step();
    e = '0; e.memRead = 1'b1; e.isWord = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("fto_fetch%0d", i), e);
      step();
    end
    e = '0; e.trap = 1'b1; e.cause = 2'b10;
    chk("fto_trap", e);
    step();
    chk("fto_trap_hold", e);
    bus.go_contr = 1'b0;
    step();
    e = '0;
    chk("fto_exit_idle", e);

    // Illegal opcode -> cause 01
    startInstr("ill", 7'b1111111, 3'b000);
    e = '0; e.trap = 1'b1; e.cause = 2'b01;
    chk("ill_trap", e);
    step();
    e = '0;
    chk("ill_exit_idle", e);

    // Store data timeout -> cause 11
    startInstr("swto", 7'b0100011, 3'b010);
    bus.mem_ready = 1'b0;
    step();
    e = '0; e.memWrite = 1'b1; e.isWord = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("swto_mem%0d", i), e);
      step();
    end
    e = '0; e.trap = 1'b1; e.cause = 2'b11;
    chk("swto_trap", e);
    step();

    // LW with mem_ready arriving exactly on the limit cycle: no trap
    startInstr("lwlim", 7'b0000011, 3'b010);
    bus.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 14; i++) step();
    bus.mem_ready = 1'b1;
    e = '0; e.memRead = 1'b1; e.isWord = 1'b1;
    chk("lwlim_mem_last", e);
    step();
    e = '0; e.regWrite = 1'b1; e.pcEn = 1'b1; e.done = 1'b1; e.m2r = 2'b01;
    chk("lwlim_wb", e);
    step();

    // Reset asserted mid-MEM of SW clears outputs without waiting for a clock
    startInstr("swrst", 7'b0100011, 3'b010);
    bus.mem_ready = 1'b0;
    step();
    e = '0; e.memWrite = 1'b1; e.isWord = 1'b1;
    chk("swrst_mem", e);
    #3 reset = 1'b1;
    #1;
    e = '0;
    chk("swrst_async_zero", e);
    #1 reset = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    chk("swrst_idle_after", e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
